// File: rtl/serial_adder_fsm.sv
// Bit-serial adder: one full-adder cell and a carry flop add two WIDTH-bit operands
// plus carry-in over WIDTH cycles. Define SERIAL_ADDER_SUB_EN to add a 'sub' input (a-b).
module serial_adder_fsm #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH);

  // Handshake: start is sampled only while busy=0; an accepted start captures a/b/cin,
  // raises busy for WIDTH+1 cycles, then done pulses for one cycle with sum/cout/ovf
  // valid; results hold until the next done. start while busy is dropped.
  typedef enum logic [1:0] {S_IDLE, S_ADD, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
  logic [WIDTH-1:0] b_ld;
  logic             c, c_ld, c_msb_in;
  logic [CNT_W-1:0] cnt;
  logic             bit_s, bit_c, last_bit, accept;

`ifdef SERIAL_ADDER_SUB_EN
  assign b_ld = sub ? ~b : b;
  assign c_ld = sub ? 1'b1 : cin;
`else
  assign b_ld = b;
  assign c_ld = cin;
`endif

  assign bit_s    = a_sh[0] ^ b_sh[0] ^ c;
  assign bit_c    = (a_sh[0] & b_sh[0]) | (a_sh[0] & c) | (b_sh[0] & c);
  assign last_bit = (cnt == CNT_W'(WIDTH - 1));
  assign busy     = (state != S_IDLE);

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      S_IDLE: if (start) begin
        accept    = 1'b1;
        state_nxt = S_ADD;
      end
      S_ADD:   if (last_bit) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh     <= '0;
      b_sh     <= '0;
      sum_sh   <= '0;
      c        <= 1'b0;
      c_msb_in <= 1'b0;
      cnt      <= '0;
      done     <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        a_sh <= a;
        b_sh <= b_ld;
        c    <= c_ld;
        cnt  <= '0;
      end else if (state == S_ADD) begin
        // LSB-first: the sum bit enters at the top so after WIDTH shifts it is aligned.
        sum_sh <= {bit_s, sum_sh[WIDTH-1:1]};
        a_sh   <= a_sh >> 1;
        b_sh   <= b_sh >> 1;
        c      <= bit_c;
        cnt    <= cnt + CNT_W'(1);
        if (last_bit) c_msb_in <= c;
      end else if (state == S_DONE) begin
        sum  <= sum_sh;
        cout <= c;
        ovf  <= c_msb_in ^ c;
        done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_fsm.sv
// Bench for serial_adder_fsm: arithmetic reference model with per-cycle compare,
// directed literal checks and randomized traffic.
module tb_serial_adder_fsm;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         busy, done, cout, ovf;
  logic [W-1:0] sum;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  serial_adder_fsm #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic, signed overflow by range check.
  function automatic void ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic ci, input logic sb,
                                  output logic [W-1:0] s, output logic co, output logic ov);
    logic [W-1:0] ye;
    logic         ce;
    logic [W:0]   full;
    longint       ss, mx, mn;
    ye   = sb ? ~y : y;
    ce   = sb ? 1'b1 : ci;
    full = {1'b0, x} + {1'b0, ye} + (W+1)'(ce);
    s    = full[W-1:0];
    co   = full[W];
    ss   = longint'($signed(x)) + longint'($signed(ye)) + longint'(ce);
    mx   = (longint'(1) << (W - 1)) - 1;
    mn   = -(longint'(1) << (W - 1));
    ov   = (ss > mx) || (ss < mn);
  endfunction

  logic         m_active, m_done, m_cout, m_ovf, p_cout, p_ovf;
  logic [W-1:0] m_sum, p_sum;
  int           m_p;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 1'b0; m_done = 1'b0; m_p = 0;
      m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_active) begin
        m_p++;
        if (m_p == W + 1) begin
          m_active = 1'b0;
          m_done = 1'b1;
          m_sum = p_sum; m_cout = p_cout; m_ovf = p_ovf;
        end
      end else if (start) begin
        m_active = 1'b1;
        m_p = 0;
        ref_add(a, b, cin, sub, p_sum, p_cout, p_ovf);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 64'(busy), 64'(m_active));
      chk("done", 64'(done), 64'(m_done));
      chk("sum",  64'(sum),  64'(m_sum));
      chk("cout", 64'(cout), 64'(m_cout));
      chk("ovf",  64'(ovf),  64'(m_ovf));
    end
  end

  task automatic op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                    input logic xs, input logic [W-1:0] es, input logic ec,
                    input logic eo, input string nm);
    int lat = 0;
    int bcnt = 0;
    bit got = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; a = xa; b = xb; cin = xc; sub = xs;
    @(posedge clk); #1;
    start = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom_range(0, 1));
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (busy) bcnt++;
      if (done) got = 1'b1;
    end
    chk({nm, " done seen"}, 64'(got), 64'(1));
    if (got) begin
      chk({nm, " latency"}, 64'(lat), 64'(W + 2));
      chk({nm, " busy cycles"}, 64'(bcnt), 64'(W + 1));
      chk({nm, " sum"}, 64'(sum), 64'(es));
      chk({nm, " cout"}, 64'(cout), 64'(ec));
      chk({nm, " ovf"}, 64'(ovf), 64'(eo));
    end
  endtask

  initial begin
    int ndone;
    logic [W-1:0] first_sum;
    int tq[$];

    #2;
    chk("reset busy", 64'(busy), 64'(0));
    chk("reset done", 64'(done), 64'(0));
    chk("reset sum",  64'(sum),  64'(0));
    chk("reset cout", 64'(cout), 64'(0));
    chk("reset ovf",  64'(ovf),  64'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;

    op(8'h3C, 8'h5A, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1, "3c+5a");
    op(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "ff+01");
    op(8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1, "7f+00+1");

    // start pulsed 3 cycles into an operation must be dropped
    @(posedge clk); #1;
    start = 1'b1; a = 8'h3C; b = 8'h5A; cin = 1'b0;
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1 start = 1'b1; a = 8'h11; b = 8'h22; cin = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    ndone = 0; first_sum = '0;
    repeat (25) begin
      @(negedge clk);
      if (done) begin ndone++; first_sum = sum; end
    end
    chk("ignored start done count", 64'(ndone), 64'(1));
    chk("ignored start sum", 64'(first_sum), 64'(8'h96));
    op(8'h11, 8'h22, 1'b1, 1'b0, 8'h34, 1'b0, 1'b0, "after ignore");

    // reset in the middle of ADD
    @(posedge clk); #1;
    start = 1'b1; a = 8'hA5; b = 8'h5A; cin = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midreset busy", 64'(busy), 64'(0));
    chk("midreset sum",  64'(sum),  64'(0));
    chk("midreset cout", 64'(cout), 64'(0));
    chk("midreset ovf",  64'(ovf),  64'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    ndone = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("midreset no done", 64'(ndone), 64'(0));
    op(8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, "80+80");

    // start held high: one accept every W+2 cycles
    @(posedge clk); #1 start = 1'b1;
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      if (done) tq.push_back(i);
      @(posedge clk); #1;
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom_range(0, 1));
    end
    start = 1'b0;
    chk("b2b done count", 64'(tq.size() >= 4), 64'(1));
    for (int i = 1; i < tq.size(); i++) chk("b2b spacing", 64'(tq[i] - tq[i-1]), 64'(W + 2));
    repeat (12) @(posedge clk);

`ifdef SERIAL_ADDER_SUB_EN
    op(8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, "05-07");
    op(8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1, "80-01");
    op(8'h07, 8'h05, 1'b1, 1'b0, 8'h0D, 1'b0, 1'b0, "07+05+1 sub0");
`endif

    // random traffic, including starts while busy
    for (int n = 0; n < 60; n++) begin
      @(posedge clk); #1;
      start = 1'b1; a = W'($urandom); b = W'($urandom); cin = 1'($urandom_range(0, 1));
`ifdef SERIAL_ADDER_SUB_EN
      sub = 1'($urandom_range(0, 1));
`endif
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1 start = 1'b0;
      repeat ($urandom_range(0, 12)) @(posedge clk);
    end
    sub = 1'b0;
    repeat (15) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
